// File: rtl/gf180mcu_cell_bist_pkg.sv
// Shared types and the OAI21 golden function for the cell self-test exerciser.
// The bench scoreboard uses the same function as the RTL comparator.
package gf180mcu_cell_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam int VEC_W   = 3;
  localparam int NUM_VEC = 8;

  // vec is {A1,A2,B}
  function automatic logic oai21_expected(input logic [VEC_W-1:0] vec);
    return ~((vec[2] | vec[1]) & vec[0]);
  endfunction

endpackage

// File: rtl/oai21_result_tracker.sv
// Result bookkeeping for the OAI21 exerciser: saturating mismatch count,
// first-failing-vector capture and the pass flag presented in FINISH.
module oai21_result_tracker #(
  parameter int ERR_W = 8
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    clear_i,
  input  logic                                    sample_i,
  input  logic                                    mismatch_i,
  input  logic [gf180mcu_cell_bist_pkg::VEC_W-1:0] vec_i,
  input  logic                                    finish_i,
  output logic [ERR_W-1:0]                        err_cnt_o,
  output logic [gf180mcu_cell_bist_pkg::VEC_W-1:0] fail_vec_o,
  output logic                                    fail_valid_o,
  output logic                                    pass_o
);
  import gf180mcu_cell_bist_pkg::*;

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  logic [ERR_W-1:0] err_q, err_d;
  logic [VEC_W-1:0] fail_vec_q, fail_vec_d;
  logic             fail_valid_q, fail_valid_d;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cnt);
    return (cnt == ERR_MAX) ? ERR_MAX : cnt + 1'b1;
  endfunction

  always_comb begin
    err_d        = err_q;
    fail_vec_d   = fail_vec_q;
    fail_valid_d = fail_valid_q;
    if (clear_i) begin
      err_d        = '0;
      fail_vec_d   = '0;
      fail_valid_d = 1'b0;
    end else if (sample_i && mismatch_i) begin
      err_d = sat_inc(err_q);
      if (!fail_valid_q) begin
        fail_vec_d   = vec_i;
        fail_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q        <= '0;
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
    end else begin
      err_q        <= err_d;
      fail_vec_q   <= fail_vec_d;
      fail_valid_q <= fail_valid_d;
    end
  end

  assign err_cnt_o    = err_q;
  assign fail_vec_o   = fail_vec_q;
  assign fail_valid_o = fail_valid_q;
  assign pass_o       = finish_i && (err_q == '0);

endmodule

// File: rtl/oai21_cell_exerciser.sv
// Self-test initiator for an OAI21 cell: sweeps {A1,A2,B} through all eight
// vectors PASSES times, samples ZN after a settle window and reports results.
module oai21_cell_exerciser #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ZN,
  output logic             A1,
  output logic             A2,
  output logic             B,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [2:0]       FAIL_VEC,
  output logic             FAIL_VALID,
  inout  wire              VDD,
  inout  wire              VSS
);
  import gf180mcu_cell_bist_pkg::*;

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int PW = $clog2(PASSES + 1);
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0]    PASS_LAST   = PW'(PASSES - 1);
  localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(NUM_VEC - 1);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [PW-1:0]    pass_q, pass_d;
  logic             clear, sample, mismatch;

  // Supply pins are carried for netlist connectivity only.
  wire unused_supply;
  assign unused_supply = VDD ^ VSS;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    pass_d   = pass_q;
    clear    = 1'b0;
    sample   = 1'b0;
    case (state_q)
      IDLE, FINISH: begin
        if (START) begin
          state_d  = SETTLE;
          vec_d    = '0;
          settle_d = '0;
          pass_d   = '0;
          clear    = 1'b1;
        end
      end
      SETTLE: begin
        settle_d = settle_q + 1'b1;
        if (settle_q == SETTLE_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        sample = 1'b1;
        if (vec_q == VEC_LAST && pass_q == PASS_LAST) begin
          state_d = FINISH;
          vec_d   = '0;
        end else begin
          vec_d    = vec_q + 1'b1;
          settle_d = '0;
          state_d  = SETTLE;
          if (vec_q == VEC_LAST) pass_d = pass_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      pass_q   <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      pass_q   <= pass_d;
    end
  end

  // vec_q is the registered drive; it is forced to zero outside a run.
  assign {A1, A2, B} = vec_q;
  assign BUSY        = (state_q == SETTLE) || (state_q == SAMPLE);
  assign DONE        = (state_q == FINISH);
  assign mismatch    = (ZN != oai21_expected(vec_q));

  oai21_result_tracker #(
    .ERR_W(ERR_W)
  ) u_tracker (
    .clk_i       (CLK),
    .rst_i       (RST),
    .clear_i     (clear),
    .sample_i    (sample),
    .mismatch_i  (mismatch),
    .vec_i       (vec_q),
    .finish_i    (DONE),
    .err_cnt_o   (ERR_CNT),
    .fail_vec_o  (FAIL_VEC),
    .fail_valid_o(FAIL_VALID),
    .pass_o      (PASS)
  );

endmodule

// File: tb/tb_oai21_cell_exerciser.sv
// Directed bench for oai21_cell_exerciser: default instance with a selectable
// ZN fault model, plus a PASSES=3/ERR_W=2 instance for counter saturation.
module tb_oai21_cell_exerciser;
  import gf180mcu_cell_bist_pkg::*;

  logic clk, rst;
  logic start1, zn1, a1_1, a2_1, b_1, busy1, done1, pass1, fv1;
  logic [7:0] err1;
  logic [2:0] fvec1;
  logic start2, zn2, a1_2, a2_2, b_2, busy2, done2, pass2, fv2;
  logic [1:0] err2;
  logic [2:0] fvec2;
  wire vdd, vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  int total = 0;
  int bad   = 0;
  int mode  = 0;
  logic [2:0] v1;
  assign v1 = {a1_1, a2_1, b_1};

  // 0: good cell, 1: stuck-at-1, 2: stuck-at-0, 3: wrong output at vec 1 and 6
  always_comb begin
    case (mode)
      0:       zn1 = oai21_expected(v1);
      1:       zn1 = 1'b1;
      2:       zn1 = 1'b0;
      default: zn1 = oai21_expected(v1) ^ ((v1 == 3'd1) || (v1 == 3'd6));
    endcase
  end
  assign zn2 = 1'b0;

  oai21_cell_exerciser dut1 (
    .CLK(clk), .RST(rst), .START(start1), .ZN(zn1),
    .A1(a1_1), .A2(a2_1), .B(b_1), .BUSY(busy1), .DONE(done1), .PASS(pass1),
    .ERR_CNT(err1), .FAIL_VEC(fvec1), .FAIL_VALID(fv1), .VDD(vdd), .VSS(vss)
  );

  oai21_cell_exerciser #(.SETTLE_CYCLES(2), .PASSES(3), .ERR_W(2)) dut2 (
    .CLK(clk), .RST(rst), .START(start2), .ZN(zn2),
    .A1(a1_2), .A2(a2_2), .B(b_2), .BUSY(busy2), .DONE(done2), .PASS(pass2),
    .ERR_CNT(err2), .FAIL_VEC(fvec2), .FAIL_VALID(fv2), .VDD(vdd), .VSS(vss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse START on dut1 and count edges from acceptance until DONE.
  task automatic run1(output int n);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0;
    while (done1 !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({a1_1, a2_1, b_1, busy1, done1, pass1, fv1, err1, fvec1} !== 18'd0) begin
      bad++; $display("FAIL reset_dut1 got=%h want=0", {a1_1, a2_1, b_1, busy1, done1, pass1, fv1, err1, fvec1});
    end
    total++;
    if ({a1_2, a2_2, b_2, busy2, done2, pass2, fv2, err2, fvec2} !== 12'd0) begin
      bad++; $display("FAIL reset_dut2 got=%h want=0", {a1_2, a2_2, b_2, busy2, done2, pass2, fv2, err2, fvec2});
    end
  endtask

  task automatic test_fault_free();
    mode = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (k > 0) tick();
      total++;
      if (v1 !== 3'(k / 3) || busy1 !== 1'b1 || done1 !== 1'b0) begin
        bad++; $display("FAIL sweep_edge%0d vec=%b busy=%b done=%b want vec=%b busy=1 done=0", k, v1, busy1, done1, 3'(k / 3));
      end
    end
    tick();
    total++;
    if (done1 !== 1'b1 || pass1 !== 1'b1 || err1 !== 8'd0 || fv1 !== 1'b0 || v1 !== 3'd0 || busy1 !== 1'b0) begin
      bad++; $display("FAIL good_finish done=%b pass=%b err=%0d fv=%b vec=%b busy=%b want 1 1 0 0 000 0", done1, pass1, err1, fv1, v1, busy1);
    end
  endtask

  task automatic test_stuck1();
    int n;
    mode = 1;
    run1(n);
    total++;
    if (n !== 24) begin bad++; $display("FAIL sa1_latency got=%0d want=24", n); end
    total++;
    if (err1 !== 8'd3 || fvec1 !== 3'b011 || fv1 !== 1'b1 || pass1 !== 1'b0) begin
      bad++; $display("FAIL sa1_result err=%0d fvec=%b fv=%b pass=%b want 3 011 1 0", err1, fvec1, fv1, pass1);
    end
  endtask

  task automatic test_stuck0();
    int n;
    mode = 2;
    run1(n);
    total++;
    if (n !== 24) begin bad++; $display("FAIL sa0_latency got=%0d want=24", n); end
    total++;
    if (err1 !== 8'd5 || fvec1 !== 3'b000 || fv1 !== 1'b1 || pass1 !== 1'b0) begin
      bad++; $display("FAIL sa0_result err=%0d fvec=%b fv=%b pass=%b want 5 000 1 0", err1, fvec1, fv1, pass1);
    end
  endtask

  task automatic test_saturate();
    int n;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    total++;
    if (n !== 72) begin bad++; $display("FAIL sat_latency got=%0d want=72", n); end
    total++;
    if (err2 !== 2'd3 || pass2 !== 1'b0 || fvec2 !== 3'b000 || fv2 !== 1'b1) begin
      bad++; $display("FAIL sat_result err=%0d pass=%b fvec=%b fv=%b want 3 0 000 1", err2, pass2, fvec2, fv2);
    end
  endtask

  task automatic test_restart_ignored_then_reset();
    int n;
    mode = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    total++;
    if (v1 !== 3'd3 || busy1 !== 1'b1) begin
      bad++; $display("FAIL ignore_start_e10 vec=%b busy=%b want 011 1", v1, busy1);
    end
    tick();
    total++;
    if (v1 !== 3'd3 || busy1 !== 1'b1) begin
      bad++; $display("FAIL ignore_start_e11 vec=%b busy=%b want 011 1", v1, busy1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({a1_1, a2_1, b_1, busy1, done1, pass1, fv1, err1, fvec1} !== 18'd0) begin
      bad++; $display("FAIL midrun_reset got=%h want=0", {a1_1, a2_1, b_1, busy1, done1, pass1, fv1, err1, fvec1});
    end
    tick();
    total++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || v1 !== 3'd0) begin
      bad++; $display("FAIL stays_idle busy=%b done=%b vec=%b want 0 0 000", busy1, done1, v1);
    end
    run1(n);
    total++;
    if (n !== 24 || pass1 !== 1'b1 || err1 !== 8'd0) begin
      bad++; $display("FAIL rerun n=%0d pass=%b err=%0d want 24 1 0", n, pass1, err1);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    mode = 3;
    run1(n);
    total++;
    if (n !== 24 || err1 !== 8'd2 || fvec1 !== 3'b001 || fv1 !== 1'b1 || pass1 !== 1'b0) begin
      bad++; $display("FAIL two_err n=%0d err=%0d fvec=%b fv=%b pass=%b want 24 2 001 1 0", n, err1, fvec1, fv1, pass1);
    end
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    total++;
    if (err1 !== 8'd0 || fv1 !== 1'b0 || fvec1 !== 3'd0 || v1 !== 3'd0 || busy1 !== 1'b1 || done1 !== 1'b0 || pass1 !== 1'b0) begin
      bad++; $display("FAIL restart_clear err=%0d fv=%b fvec=%b vec=%b busy=%b done=%b pass=%b want 0 0 000 000 1 0 0",
                      err1, fv1, fvec1, v1, busy1, done1, pass1);
    end
    n = 0;
    while (done1 !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (n !== 24 || err1 !== 8'd2) begin
      bad++; $display("FAIL restart_run n=%0d err=%0d want 24 2", n, err1);
    end
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
    test_reset();
    test_fault_free();
    test_stuck1();
    test_stuck0();
    test_saturate();
    test_restart_ignored_then_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
